// File: rtl/rv32_pkg.sv
// ============================================================================
// Module      : rv32_pkg
// Description : Shared RV32I constants and the regfile dumper state type.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package rv32_pkg;

    localparam int XLEN       = 32;
    localparam int NUM_REGS   = 32;
    localparam int REG_ADDR_W = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        SEND = 2'd2,
        DONE = 2'd3
    } dump_state_t;

endpackage

`default_nettype wire

// File: rtl/regfile_dumper.sv
// ============================================================================
// Module      : regfile_dumper
// Description : Stalls the core and streams every architectural register out
//               as an (index, value) beat on a valid/ready interface.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module regfile_dumper #(
    parameter int NUM_REGS = rv32_pkg::NUM_REGS,
    parameter int ADDR_W   = rv32_pkg::REG_ADDR_W,
    parameter int DATA_W   = rv32_pkg::XLEN,
    parameter int SKIP_X0  = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [ADDR_W-1:0] rf_raddr,
    input  logic [DATA_W-1:0] rf_rdata,
    output logic              cpu_stall,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_addr,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              busy,
    output logic              done
);

    import rv32_pkg::*;

    localparam logic [ADDR_W-1:0] c_last_idx  = ADDR_W'(NUM_REGS - 1);
    localparam logic [ADDR_W-1:0] c_first_idx = (SKIP_X0 != 0) ? ADDR_W'(1) : '0;

    dump_state_t       r_state;
    dump_state_t       w_state_nxt;
    logic [ADDR_W-1:0] r_idx;
    logic [ADDR_W-1:0] w_idx_nxt;
    logic              r_out_valid;
    logic              w_out_valid_nxt;
    logic [ADDR_W-1:0] r_out_addr;
    logic [ADDR_W-1:0] w_out_addr_nxt;
    logic [DATA_W-1:0] r_out_data;
    logic [DATA_W-1:0] w_out_data_nxt;
    logic              r_out_last;
    logic              w_out_last_nxt;
    logic [ADDR_W-1:0] w_rf_raddr;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_idx       <= '0;
            r_out_valid <= 1'b0;
            r_out_addr  <= '0;
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_idx       <= w_idx_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_out_addr  <= w_out_addr_nxt;
            r_out_data  <= w_out_data_nxt;
            r_out_last  <= w_out_last_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_idx_nxt       = r_idx;
        w_out_valid_nxt = r_out_valid;
        w_out_addr_nxt  = r_out_addr;
        w_out_data_nxt  = r_out_data;
        w_out_last_nxt  = r_out_last;
        w_rf_raddr      = '0;

        case (r_state)
            IDLE: begin
                if (start) begin
                    w_idx_nxt   = c_first_idx;
                    w_state_nxt = READ;
                end
            end
            READ: begin
                w_rf_raddr      = r_idx;
                w_out_data_nxt  = rf_rdata;
                w_out_addr_nxt  = r_idx;
                w_out_last_nxt  = (r_idx == c_last_idx);
                w_out_valid_nxt = 1'b1;
                w_state_nxt     = SEND;
            end
            SEND: begin
                // Beat fields stay frozen until the sink takes the beat.
                if (r_out_valid && out_ready) begin
                    w_out_valid_nxt = 1'b0;
                    if (r_out_last) begin
                        w_state_nxt = DONE;
                    end else begin
                        w_idx_nxt   = r_idx + 1'b1;
                        w_state_nxt = READ;
                    end
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign rf_raddr  = w_rf_raddr;
    assign out_valid = r_out_valid;
    assign out_addr  = r_out_addr;
    assign out_data  = r_out_data;
    assign out_last  = r_out_last;
    assign busy      = (r_state != IDLE);
    assign cpu_stall = (r_state != IDLE);
    assign done      = (r_state == DONE);

endmodule

`default_nettype wire

// File: tb/tb_regfile_dumper.sv
// ============================================================================
// Module      : tb_regfile_dumper
// Description : Directed self-checking bench for regfile_dumper (x0 kept and
//               x0 skipped instances).
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_regfile_dumper;

    logic        clk;
    logic        rst;

    logic        start0, ready0;
    logic [4:0]  raddr0, addr0;
    logic [31:0] rdata0, data0;
    logic        stall0, valid0, last0, busy0, done0;

    logic        start1, ready1;
    logic [4:0]  raddr1, addr1;
    logic [31:0] rdata1, data1;
    logic        stall1, valid1, last1, busy1, done1;

    int checks;
    int errors;

    // Regfile model: x0 reads zero, xi reads 0x1000_0000 + i.
    function automatic logic [31:0] rf_model(input logic [4:0] a);
        return (a == 5'd0) ? 32'h0 : (32'h1000_0000 | {27'd0, a});
    endfunction

    assign rdata0 = rf_model(raddr0);
    assign rdata1 = rf_model(raddr1);

    regfile_dumper #(.NUM_REGS(32), .ADDR_W(5), .DATA_W(32), .SKIP_X0(0)) u_dut0 (
        .clk(clk), .rst(rst), .start(start0),
        .rf_raddr(raddr0), .rf_rdata(rdata0), .cpu_stall(stall0),
        .out_valid(valid0), .out_ready(ready0), .out_addr(addr0),
        .out_data(data0), .out_last(last0), .busy(busy0), .done(done0)
    );

    regfile_dumper #(.NUM_REGS(32), .ADDR_W(5), .DATA_W(32), .SKIP_X0(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1),
        .rf_raddr(raddr1), .rf_rdata(rdata1), .cpu_stall(stall1),
        .out_valid(valid1), .out_ready(ready1), .out_addr(addr1),
        .out_data(data1), .out_last(last1), .busy(busy1), .done(done1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, actual=running required=finished");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; start0 = 1'b1; start1 = 1'b1; ready0 = 1'b1; ready1 = 1'b1;
        step();
        step();
        checks++;
        if ({valid0, busy0, stall0, done0, last0} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags0 actual=%b required=00000", {valid0, busy0, stall0, done0, last0});
        end
        checks++;
        if ({raddr0, addr0, data0} !== 42'd0) begin
            errors++;
            $display("FAIL reset_fields0 raddr=%0d addr=%0d data=%h required all zero", raddr0, addr0, data0);
        end
        checks++;
        if ({valid1, busy1, stall1, done1, last1} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags1 actual=%b required=00000", {valid1, busy1, stall1, done1, last1});
        end
        rst = 1'b0; start0 = 1'b0; start1 = 1'b0;
        step();
        checks++;
        if (busy0 !== 1'b0 || valid0 !== 1'b0) begin
            errors++;
            $display("FAIL reset_release busy=%b valid=%b required busy=0 valid=0", busy0, valid0);
        end
    endtask

    task automatic test_full_dump();
        int e = 0;
        int ndone = 0;
        int done_cyc = -1;
        logic [31:0] exp_d;
        ready0 = 1'b1;
        start0 = 1'b1;
        step();
        start0 = 1'b0;
        checks++;
        if (busy0 !== 1'b1 || stall0 !== 1'b1 || raddr0 !== 5'd0) begin
            errors++;
            $display("FAIL full_first_read busy=%b stall=%b raddr=%0d required 1 1 0", busy0, stall0, raddr0);
        end
        for (int i = 1; i <= 70; i++) begin
            step();
            if (i <= 64) begin
                checks++;
                if (busy0 !== 1'b1 || stall0 !== 1'b1) begin
                    errors++;
                    $display("FAIL full_busy cycle=%0d busy=%b stall=%b required 1 1", i, busy0, stall0);
                end
            end
            if (valid0 === 1'b1) begin
                exp_d = (e == 0) ? 32'h0 : 32'h1000_0000 + 32'(e);
                checks++;
                if ((i % 2) != 1 || addr0 !== 5'(e) || data0 !== exp_d || last0 !== (e == 31)) begin
                    errors++;
                    $display("FAIL full_beat cycle=%0d addr=%0d data=%h last=%b required addr=%0d data=%h last=%b odd cycle",
                             i, addr0, data0, last0, e, exp_d, (e == 31));
                end
                e++;
            end
            if (done0 === 1'b1) begin
                ndone++;
                done_cyc = i;
            end
        end
        checks++;
        if (e != 32) begin
            errors++;
            $display("FAIL full_beat_count actual=%0d required=32", e);
        end
        checks++;
        if (ndone != 1 || done_cyc != 64) begin
            errors++;
            $display("FAIL full_done count=%0d cycle=%0d required count=1 cycle=64", ndone, done_cyc);
        end
        checks++;
        if (busy0 !== 1'b0) begin
            errors++;
            $display("FAIL full_idle busy=%b required=0", busy0);
        end
    endtask

    task automatic test_backpressure();
        bit found = 1'b0;
        bit saw_done = 1'b0;
        ready0 = 1'b1;
        start0 = 1'b1;
        step();
        start0 = 1'b0;
        for (int c = 0; c < 40 && !found; c++) begin
            step();
            if (valid0 === 1'b1 && addr0 == 5'd5) found = 1'b1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL bp_reach_beat5 actual=not_seen required=seen");
        end
        ready0 = 1'b0;
        for (int c = 0; c < 3; c++) begin
            step();
            checks++;
            if (valid0 !== 1'b1 || addr0 !== 5'd5 || data0 !== 32'h1000_0005 || last0 !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold cycle=%0d valid=%b addr=%0d data=%h last=%b required 1 5 10000005 0",
                         c, valid0, addr0, data0, last0);
            end
        end
        ready0 = 1'b1;
        step();
        checks++;
        if (valid0 !== 1'b0) begin
            errors++;
            $display("FAIL bp_after_accept valid=%b required=0", valid0);
        end
        step();
        checks++;
        if (valid0 !== 1'b1 || addr0 !== 5'd6 || data0 !== 32'h1000_0006) begin
            errors++;
            $display("FAIL bp_beat6 valid=%b addr=%0d data=%h required 1 6 10000006", valid0, addr0, data0);
        end
        for (int c = 0; c < 100 && !saw_done; c++) begin
            step();
            if (done0 === 1'b1) saw_done = 1'b1;
        end
        checks++;
        if (!saw_done) begin
            errors++;
            $display("FAIL bp_done actual=timeout required=done");
        end
        step();
    endtask

    task automatic test_ignored_start();
        int nbeats = 0;
        int ndone = 0;
        bit busy_after_done = 1'b0;
        ready0 = 1'b1;
        start0 = 1'b1;
        step();
        start0 = 1'b0;
        for (int i = 1; i <= 80; i++) begin
            step();
            start0 = 1'b0;
            if (ndone > 0 && done0 !== 1'b1 && busy0 !== 1'b0) busy_after_done = 1'b1;
            if (valid0 === 1'b1) begin
                nbeats++;
                if (addr0 == 5'd10) start0 = 1'b1;
            end
            if (done0 === 1'b1) begin
                ndone++;
                start0 = 1'b1;
            end
        end
        start0 = 1'b0;
        checks++;
        if (nbeats != 32) begin
            errors++;
            $display("FAIL ign_beats actual=%0d required=32", nbeats);
        end
        checks++;
        if (ndone != 1) begin
            errors++;
            $display("FAIL ign_done actual=%0d required=1", ndone);
        end
        checks++;
        if (busy_after_done || busy0 !== 1'b0 || valid0 !== 1'b0) begin
            errors++;
            $display("FAIL ign_restart busy_after_done=%b busy=%b valid=%b required 0 0 0",
                     busy_after_done, busy0, valid0);
        end
    endtask

    task automatic test_reset_mid();
        bit found = 1'b0;
        bit bad = 1'b0;
        bit saw_done = 1'b0;
        ready0 = 1'b1;
        start0 = 1'b1;
        step();
        start0 = 1'b0;
        for (int c = 0; c < 40 && !found; c++) begin
            step();
            if (valid0 === 1'b1 && addr0 == 5'd10) found = 1'b1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL rstmid_reach_beat10 actual=not_seen required=seen");
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if ({valid0, busy0, stall0, done0, last0} !== 5'b0 || {raddr0, addr0, data0} !== 42'd0) begin
            errors++;
            $display("FAIL rstmid_outputs flags=%b raddr=%0d addr=%0d data=%h required all zero",
                     {valid0, busy0, stall0, done0, last0}, raddr0, addr0, data0);
        end
        for (int c = 0; c < 5; c++) begin
            step();
            if (done0 !== 1'b0 || busy0 !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL rstmid_no_done actual=activity required=idle");
        end
        start0 = 1'b1;
        step();
        start0 = 1'b0;
        checks++;
        if (raddr0 !== 5'd0 || busy0 !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_restart_read raddr=%0d busy=%b required 0 1", raddr0, busy0);
        end
        step();
        checks++;
        if (valid0 !== 1'b1 || addr0 !== 5'd0 || data0 !== 32'h0) begin
            errors++;
            $display("FAIL rstmid_restart_beat valid=%b addr=%0d data=%h required 1 0 00000000",
                     valid0, addr0, data0);
        end
        for (int c = 0; c < 100 && !saw_done; c++) begin
            step();
            if (done0 === 1'b1) saw_done = 1'b1;
        end
        checks++;
        if (!saw_done) begin
            errors++;
            $display("FAIL rstmid_drain actual=timeout required=done");
        end
        step();
    endtask

    task automatic test_skip_x0();
        int e = 1;
        int ndone = 0;
        int done_cyc = -1;
        ready1 = 1'b1;
        start1 = 1'b1;
        step();
        start1 = 1'b0;
        for (int i = 1; i <= 70; i++) begin
            step();
            if (valid1 === 1'b1) begin
                checks++;
                if (addr1 !== 5'(e) || data1 !== (32'h1000_0000 + 32'(e)) || last1 !== (e == 31)) begin
                    errors++;
                    $display("FAIL skip_beat cycle=%0d addr=%0d data=%h last=%b required addr=%0d data=%h last=%b",
                             i, addr1, data1, last1, e, 32'h1000_0000 + 32'(e), (e == 31));
                end
                e++;
            end
            if (done1 === 1'b1) begin
                ndone++;
                done_cyc = i;
            end
        end
        checks++;
        if (e != 32) begin
            errors++;
            $display("FAIL skip_beat_count actual=%0d required=31", e - 1);
        end
        checks++;
        if (ndone != 1 || done_cyc != 62) begin
            errors++;
            $display("FAIL skip_done count=%0d cycle=%0d required count=1 cycle=62", ndone, done_cyc);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        start0 = 1'b0; start1 = 1'b0;
        ready0 = 1'b0; ready1 = 1'b0;
        test_reset();
        test_full_dump();
        test_backpressure();
        test_ignored_start();
        test_reset_mid();
        test_skip_x0();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
